// File: rtl/fir_lpf_mc.sv
// Multichannel decimating FIR low-pass filter with a single time-shared MAC.
// All channels share one coefficient RAM; results are full precision (OW bits).
module fir_lpf_mc #(
    parameter  int DW    = 16,
    parameter  int CW    = 16,
    parameter  int TAPS  = 32,
    parameter  int CH    = 2,
    parameter  int DECIM = 1,
    localparam int OW    = DW + CW + $clog2(TAPS)
) (
    input  logic                     clk4M,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [CH*DW-1:0]         din,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [CW-1:0]            coef_data,
    input  logic                     overrun_clr,
    output logic [CH*OW-1:0]         dout,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int AW  = $clog2(TAPS);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PW  = DW + CW;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                 state, state_nx;
    logic signed [DW-1:0]   dline [CH][TAPS];
    logic signed [CW-1:0]   coef  [TAPS];
    logic signed [OW-1:0]   acc   [CH];
    logic [AW-1:0]          wptr, base, rd, k;
    logic [CHW-1:0]         chi, pch;
    logic [DCW-1:0]         dcnt;
    logic signed [PW-1:0]   prod, mul;
    logic signed [DW-1:0]   x_sel;
    logic signed [CW-1:0]   c_sel;
    logic                   pv, pk0, drain;
    logic                   idle, accept, trig, last_k, last_ch;

    assign idle    = (state == S_IDLE);
    assign accept  = in_valid && idle;
    assign trig    = accept && (dcnt == DCW'(DECIM - 1));
    assign last_k  = (k == AW'(TAPS - 1));
    assign last_ch = (chi == CHW'(CH - 1));
    assign busy    = !idle;

    // rd walks backwards from the newest sample: x[newest-k mod TAPS]
    assign x_sel = dline[chi][rd];
    assign c_sel = coef[k];
    assign mul   = $signed({{CW{x_sel[DW-1]}}, x_sel}) * $signed({{DW{c_sel[CW-1]}}, c_sel});

    always_ff @(posedge clk4M or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (trig) state_nx = S_MAC;
            S_MAC:   if (last_k && last_ch) state_nx = S_OUT;
            S_OUT:   if (drain) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk4M or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            base      <= '0;
            rd        <= '0;
            k         <= '0;
            chi       <= '0;
            pch       <= '0;
            dcnt      <= '0;
            prod      <= '0;
            pv        <= 1'b0;
            pk0       <= 1'b0;
            drain     <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            dout      <= '0;
            for (int c = 0; c < CH; c++) begin
                acc[c] <= '0;
                for (int t = 0; t < TAPS; t++) dline[c][t] <= '0;
            end
            for (int t = 0; t < TAPS; t++) coef[t] <= (t == 0) ? CW'(1) : '0;
        end else begin
            out_valid <= 1'b0;
            pv        <= 1'b0;

            if (coef_we && idle) coef[coef_addr] <= coef_data;

            // a drop in the same cycle as a clear leaves the flag set
            if (in_valid && !idle) overrun <= 1'b1;
            else if (overrun_clr)  overrun <= 1'b0;

            if (accept) begin
                for (int c = 0; c < CH; c++) dline[c][wptr] <= din[c*DW +: DW];
                wptr <= (wptr == AW'(TAPS - 1)) ? '0 : wptr + 1'b1;
                dcnt <= (dcnt == DCW'(DECIM - 1)) ? '0 : dcnt + 1'b1;
                if (trig) begin
                    base <= wptr;
                    rd   <= wptr;
                    k    <= '0;
                    chi  <= '0;
                end
            end

            // product registered, accumulated one cycle later
            if (state == S_MAC) begin
                prod <= mul;
                pv   <= 1'b1;
                pk0  <= (k == '0);
                pch  <= chi;
                if (last_k) begin
                    k   <= '0;
                    chi <= chi + 1'b1;
                    rd  <= base;
                end else begin
                    k   <= k + 1'b1;
                    rd  <= (rd == '0) ? AW'(TAPS - 1) : rd - 1'b1;
                end
            end

            if (pv)
                acc[pch] <= pk0 ? {{(OW-PW){prod[PW-1]}}, prod}
                                : acc[pch] + {{(OW-PW){prod[PW-1]}}, prod};

            // OUT spends one cycle draining the pipeline, then publishes
            if (state == S_OUT) begin
                drain <= !drain;
                if (drain) begin
                    out_valid <= 1'b1;
                    for (int c = 0; c < CH; c++) dout[c*OW +: OW] <= acc[c];
                end
            end
        end
    end

endmodule

// File: doc/fir_lpf_mc.md
FIR_LPF_MC -- requirements
Module: fir_lpf_mc

Interface
REQ-001 SHALL provide parameter DW, default 16: signed input sample width per channel.
REQ-002 SHALL provide parameter CW, default 16: signed coefficient width.
REQ-003 SHALL provide parameter TAPS, default 32, range 2..256: filter length.
REQ-004 SHALL provide parameter CH, default 2, range 1..8: channel count; all channels share the coefficients.
REQ-005 SHALL provide parameter DECIM, default 1, range 1..16: decimation ratio.
REQ-006 SHALL use derived width OW = DW+CW+clog2(TAPS): output width per channel.
REQ-007 SHALL provide port clk4M, input, 1: system clock, rising edge.
REQ-008 SHALL provide port rst_n, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL provide port in_valid, input, 1: one-cycle sample strobe.
REQ-010 SHALL provide port din, input, CH*DW: packed signed samples, channel 0 in the LSBs.
REQ-011 SHALL provide port coef_we, input, 1: coefficient write strobe.
REQ-012 SHALL provide port coef_addr, input, clog2(TAPS): tap index.
REQ-013 SHALL provide port coef_data, input, CW: signed coefficient value.
REQ-014 SHALL provide port overrun_clr, input, 1: clears overrun.
REQ-015 SHALL provide port dout, output, CH*OW: packed signed results, channel 0 in the LSBs.
REQ-016 SHALL provide port out_valid, output, 1: one-cycle result strobe.
REQ-017 SHALL provide port busy, output, 1: high while the MAC runs.
REQ-018 SHALL provide port overrun, output, 1: sticky dropped-sample flag.

Function
REQ-019 SHALL keep, per channel, a circular delay line of TAPS samples with one shared write pointer.
REQ-020 SHALL, on in_valid in IDLE, write all CH samples at the write pointer and then advance the pointer modulo TAPS.
REQ-021 SHALL maintain a decimation counter 0..DECIM-1 that advances on every accepted sample.
- Counter == DECIM-1 on acceptance: counter wraps to 0 and the FSM enters MAC.
- Otherwise: the sample is stored only and the FSM stays in IDLE.
REQ-022 SHALL implement FSM states IDLE -> MAC -> OUT -> IDLE.
- MAC lasts exactly CH*TAPS cycles and performs one signed multiply-accumulate per cycle.
- Channel order is ascending; within a channel, k runs 0..TAPS-1.
- Each step computes acc += coef[k] * x[ch][newest-k mod TAPS].
REQ-023 SHALL compute y[ch] = sum over k of coef[k]*x[ch][n-k] at full precision in OW bits, with no rounding or saturation.
REQ-024 SHALL update dout and pulse out_valid for exactly one cycle on the (CH*TAPS+2)th rising edge after the edge that samples the triggering in_valid.
REQ-025 SHALL hold dout between results.
REQ-026 SHALL drive busy high from the edge after the triggering in_valid until out_valid is asserted.
REQ-027 SHALL handle in_valid while not in IDLE as follows:
- The sample is dropped and leaves the delay line and decimation counter unchanged.
- overrun is set to 1.
- The result in progress is unaffected.
REQ-028 SHALL clear overrun on overrun_clr; if overrun_clr and a drop occur in the same cycle, overrun ends at 1.
REQ-029 SHALL write coef_data to coef[coef_addr] on coef_we only in IDLE; coef_we in any other state is ignored.
REQ-030 SHALL, when coef_we and in_valid coincide in IDLE, perform both; the MAC uses the newly written coefficient.

Reset
REQ-031 SHALL, on rst_n low, asynchronously apply the following:
- dout=0, out_valid=0, busy=0, overrun=0.
- FSM=IDLE, write pointer=0, decimation counter=0.
- All delay lines cleared to 0.
- coef[0]=1 and all other coefficients 0 (passthrough).
REQ-032 SHALL abort a MAC in progress on reset, with no out_valid produced afterwards.

Verification
REQ-033 SHALL cover passthrough: TAPS=8, CH=2, DECIM=1; after reset, in_valid with ch0=100, ch1=-100 -> out_valid exactly 18 edges later, dout ch0=100, ch1=-100.
REQ-034 SHALL cover impulse response: load coef[k]=k+1 for k=0..7; feed 1 then zeros, spaced 20 cycles apart -> successive ch0 outputs 1,2,...,8,0.
REQ-035 SHALL cover full-scale: all coef=-32768, eight inputs of -32768 -> eighth output is +2^33 (OW=35), with no wrap.
REQ-036 SHALL cover overrun: in_valid 5 cycles after a triggering in_valid -> overrun=1 and the first result is unchanged; overrun_clr -> overrun=0.
REQ-037 SHALL cover decimation: DECIM=4 with 8 spaced in_valid pulses -> exactly 2 out_valid pulses, following the 4th and 8th samples.
REQ-038 SHALL cover reset during MAC: rst_n low 3 cycles into MAC -> no out_valid, dout=0, busy=0; next sample passes through unchanged.
